control_cmd_encoder: RTL and testbench

Serialises high-level controller commands into the byte stream consumed by `control_unit`: one opcode byte, then 0–6 payload bytes, most-significant first. Sits between any on-chip command source (boot sequencer, test harness, soft-CPU bridge) and `control_unit`'s `in_byte`/`in_valid`/`next` port. Waits for the controller to report READY before each command, and paces every byte on the controller's `next` acknowledge.

---
 rtl/control_cmd_encoder_pkg.sv | 46 ++++
 rtl/control_cmd_encoder.sv | 146 ++++++++++++++
 tb/tb_control_cmd_encoder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_cmd_encoder_pkg.sv
// Shared command definitions: opcodes, controller state encodings and the
// payload-length decode also used by control_unit for its byte counts.
package control_cmd_encoder_pkg;

  localparam int CMD_MAX_PAYLOAD = 6;

  // Bit 3 selects the target pipeline; it never affects the payload length.
  localparam logic [7:0] OP_PIPE_SEL          = 8'h08;

  localparam logic [7:0] OP_WRITE_BLOCK_INSTR = 8'h01;
  localparam logic [7:0] OP_WRITE_BLOCK_REG   = 8'h02;
  localparam logic [7:0] OP_UPDATE_BLOCK_REG  = 8'h03;
  localparam logic [7:0] OP_ALLOC_DELAY       = 8'h04;
  localparam logic [7:0] OP_SET_INPUT_GAIN    = 8'h05;
  localparam logic [7:0] OP_SET_OUTPUT_GAIN   = 8'h06;
  localparam logic [7:0] OP_SWAP              = 8'h07;
  localparam logic [7:0] OP_RESET_PIPELINE    = 8'h10;
  localparam logic [7:0] OP_COMMIT_REG        = 8'h11;

  localparam logic [7:0] CTRL_ST_READY        = 8'h00;
  localparam logic [7:0] CTRL_ST_RECV         = 8'h01;
  localparam logic [7:0] CTRL_ST_EXEC         = 8'h02;

  typedef struct packed {
    logic       valid;
    logic [2:0] len;
  } cmd_len_t;

  function automatic cmd_len_t cmd_payload_len(input logic [7:0] opcode);
    cmd_len_t   r;
    logic [7:0] base;
    base    = opcode & ~OP_PIPE_SEL;
    r.valid = 1'b1;
    r.len   = 3'd0;
    case (base)
      OP_WRITE_BLOCK_INSTR:                    r.len = 3'd5;
      OP_WRITE_BLOCK_REG, OP_UPDATE_BLOCK_REG: r.len = 3'd3;
      OP_ALLOC_DELAY:                          r.len = 3'd6;
      OP_SET_INPUT_GAIN, OP_SET_OUTPUT_GAIN:   r.len = 3'd2;
      OP_SWAP, OP_RESET_PIPELINE, OP_COMMIT_REG: r.len = 3'd0;
      default:                                 r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_cmd_encoder.sv
// Serialises one command (opcode + 0..6 payload bytes, MSB first) towards
// control_unit, paced by its next pulse. Optional CMD_ENC_TIMEOUT_EN aborts a stuck byte.
module control_cmd_encoder
  import control_cmd_encoder_pkg::*;
#(
  parameter logic [7:0] READY_STATE    = 8'd0,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_opcode,
  input  logic [47:0] req_payload,
  input  logic [7:0]  control_state,
  input  logic        next,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_RDY = 2'd1;
  localparam logic [1:0] ST_SEND     = 2'd2;
  localparam logic [1:0] ST_GAP      = 2'd3;

  logic [1:0]  state_reg;
  logic [7:0]  opcode_reg;
  logic [47:0] payload_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  out_byte_reg;
  logic        out_valid_reg;
  logic        req_ready_reg;
  logic        done_reg;
  logic        err_reg;
  cmd_len_t    req_len;
  logic [7:0]  payload_bytes [8];

  assign req_len = cmd_payload_len(req_opcode);

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_bytes
    if (gi < CMD_MAX_PAYLOAD) begin : g_used
      assign payload_bytes[gi] = payload_reg[8*gi +: 8];
    end else begin : g_pad
      assign payload_bytes[gi] = 8'd0;
    end
  end

`ifdef CMD_ENC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_reg;
`else
  // SEND waits on next indefinitely in this build.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      opcode_reg    <= 8'd0;
      payload_reg   <= 48'd0;
      idx_reg       <= 3'd0;
      out_byte_reg  <= 8'd0;
      out_valid_reg <= 1'b0;
      req_ready_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
`ifdef CMD_ENC_TIMEOUT_EN
      to_cnt_reg    <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          req_ready_reg <= 1'b1;
          if (req_valid && req_ready_reg) begin
            opcode_reg  <= req_opcode;
            payload_reg <= req_payload;
            if (req_len.valid) begin
              idx_reg       <= req_len.len;
              state_reg     <= ST_WAIT_RDY;
              req_ready_reg <= 1'b0;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_WAIT_RDY: begin
          // READY gates only the opcode; payload bytes never re-check it.
          if (control_state == READY_STATE) begin
            out_byte_reg  <= opcode_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_SEND;
`ifdef CMD_ENC_TIMEOUT_EN
            to_cnt_reg    <= '0;
`endif
          end
        end
        ST_SEND: begin
          if (next) begin
            out_valid_reg <= 1'b0;
            if (idx_reg == 3'd0) begin
              done_reg      <= 1'b1;
              req_ready_reg <= 1'b1;
              state_reg     <= ST_IDLE;
            end else begin
              state_reg <= ST_GAP;
            end
          end
`ifdef CMD_ENC_TIMEOUT_EN
          else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b1;
            req_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
`endif
        end
        default: begin
          out_byte_reg  <= payload_bytes[idx_reg - 3'd1];
          idx_reg       <= idx_reg - 3'd1;
          out_valid_reg <= 1'b1;
          state_reg     <= ST_SEND;
`ifdef CMD_ENC_TIMEOUT_EN
          to_cnt_reg    <= '0;
`endif
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign out_byte  = out_byte_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_control_cmd_encoder.sv
// Randomised bench for control_cmd_encoder against a byte-queue reference
// model and a simple controller model that acknowledges each byte.
module tb_control_cmd_encoder;
  import control_cmd_encoder_pkg::*;

  localparam logic [7:0] READY = 8'd0;
`ifdef CMD_ENC_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 1024;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_opcode;
  logic [47:0] req_payload;
  logic [7:0]  control_state;
  logic        next;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        err;

  logic hold_next;
  int   notready_left;
  int   vectors = 0;
  int   miscompares = 0;

  control_cmd_encoder #(.READY_STATE(READY), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_payload(req_payload),
    .control_state(control_state), .next(next), .out_byte(out_byte),
    .out_valid(out_valid), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: acknowledges a valid byte one cycle after sampling it.
  initial next = 1'b0;
  always @(posedge clk) next <= !reset && !hold_next && out_valid && !next;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_state();
    control_state = (notready_left > 0) ? CTRL_ST_EXEC : READY;
    if (notready_left > 0) notready_left--;
  endtask

  // Payload length per command family; -1 marks an unknown opcode.
  function automatic int ref_len(input logic [7:0] op);
    logic [7:0] b;
    b = op;
    b[3] = 1'b0;
    case (b)
      OP_WRITE_BLOCK_INSTR:                      return 5;
      OP_WRITE_BLOCK_REG, OP_UPDATE_BLOCK_REG:   return 3;
      OP_ALLOC_DELAY:                            return 6;
      OP_SET_INPUT_GAIN, OP_SET_OUTPUT_GAIN:     return 2;
      OP_SWAP, OP_RESET_PIPELINE, OP_COMMIT_REG: return 0;
      default:                                   return -1;
    endcase
  endfunction

  task automatic wait_req_ready();
    int t;
    t = 0;
    while (!req_ready && t < 500) begin
      tick();
      drive_state();
      t++;
    end
    check("req_ready_wait", req_ready, 1'b1);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [47:0] pl);
    int n, rdy_cyc, last_next, done_cyc, unstable, errs_seen;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int rise_q[$];
    logic prev_v;
    logic [7:0] prev_b;
    n = ref_len(op);
    exp_q.push_back(op);
    for (int k = n - 1; k >= 0; k--) exp_q.push_back(pl[8*k +: 8]);
    wait_req_ready();
    req_valid = 1'b1;
    req_opcode = op;
    req_payload = pl;
    tick();
    req_valid = 1'b0;
    req_payload = {$urandom, $urandom};
    if (n < 0) begin
      check("unk_err", err, 1'b1);
      check("unk_valid", out_valid, 1'b0);
      drive_state();
      tick();
      check("unk_ready", req_ready, 1'b1);
      check("unk_err_pulse", err, 1'b0);
      check("unk_valid_after", out_valid, 1'b0);
      check("unk_busy", busy, 1'b0);
      $display("cmd op=%02h unknown err=pulse", op);
      return;
    end
    rdy_cyc = -1; last_next = -1; done_cyc = -1;
    unstable = 0; errs_seen = 0; prev_v = 1'b0; prev_b = 8'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) tick();
      if (out_valid && !prev_v) begin
        got_q.push_back(out_byte);
        rise_q.push_back(cyc);
      end
      if (out_valid && prev_v && out_byte !== prev_b) unstable++;
      if (next) last_next = cyc;
      if (err) errs_seen++;
      prev_v = out_valid;
      prev_b = out_byte;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (rdy_cyc < 0 && notready_left == 0) rdy_cyc = cyc;
      drive_state();
    end
    check("done_seen", done_cyc >= 0, 1'b1);
    check("byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    if (rise_q.size() > 0) check("opcode_latency", rise_q[0], rdy_cyc + 1);
    for (int i = 1; i < rise_q.size(); i++)
      check("byte_gap", rise_q[i] - rise_q[i-1], 3);
    if (done_cyc >= 0) begin
      check("done_after_next", done_cyc, last_next + 1);
      check("ready_with_done", req_ready, 1'b1);
    end
    check("stable", unstable, 0);
    check("no_err", errs_seen, 0);
    drive_state();
    tick();
    check("done_pulse", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    $display("cmd op=%02h n=%0d bytes=%0d done@%0d", op, n, got_q.size(), done_cyc);
    // Zero-payload commands leave the controller non-READY for a while.
    if (n == 0) notready_left = $urandom_range(2, 6);
  endtask

  logic [7:0] known_ops [9];

  initial begin
    int rises, sawdone, cnt;
    logic prev;
    logic [7:0] op;
    known_ops = '{OP_WRITE_BLOCK_INSTR, OP_WRITE_BLOCK_REG, OP_UPDATE_BLOCK_REG,
                  OP_ALLOC_DELAY, OP_SET_INPUT_GAIN, OP_SET_OUTPUT_GAIN,
                  OP_SWAP, OP_RESET_PIPELINE, OP_COMMIT_REG};
    reset = 1'b1; req_valid = 1'b0; req_opcode = 8'd0; req_payload = 48'd0;
    hold_next = 1'b0; notready_left = 0; control_state = READY;
    tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_byte", out_byte, 8'd0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    reset = 1'b0;
    tick();
    check("req_ready_after_rst", req_ready, 1'b1);

    run_cmd(OP_WRITE_BLOCK_INSTR, 48'h00_07_DEADBEEF);
    run_cmd(OP_ALLOC_DELAY, 48'h000100_000020);
    run_cmd(OP_SWAP, 48'h0);
    run_cmd(OP_SET_INPUT_GAIN, 48'h4000);
    run_cmd(8'hFF, 48'h123456789ABC);

    // Reset during the third byte of a register write.
    notready_left = 0;
    wait_req_ready();
    req_valid = 1'b1; req_opcode = OP_WRITE_BLOCK_REG; req_payload = 48'h0000_0A_BEEF;
    tick();
    req_valid = 1'b0;
    rises = 0; sawdone = 0; prev = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid && !prev) rises++;
      if (done) sawdone++;
      prev = out_valid;
      if (rises == 3) break;
      drive_state();
      tick();
    end
    check("rst_mid_byte3", rises, 3);
    reset = 1'b1;
    tick();
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done | sawdone[0], 1'b0);
    check("rst_mid_err", err, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_mid_ready", req_ready, 1'b1);
    $display("cmd reset mid-command rises=%0d", rises);
    run_cmd(OP_UPDATE_BLOCK_REG | OP_PIPE_SEL, 48'h0000_03_1234);

    // next held low while a byte is outstanding.
    hold_next = 1'b1;
    wait_req_ready();
    req_valid = 1'b1; req_opcode = OP_WRITE_BLOCK_INSTR; req_payload = 48'h1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 50 && !out_valid; c++) begin
      drive_state();
      tick();
    end
    check("hold_valid_rise", out_valid, 1'b1);
`ifdef CMD_ENC_TIMEOUT_EN
    cnt = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (err) begin
        cnt = c;
        break;
      end
    end
    check("timeout_cycles", cnt, TO_CYC);
    check("timeout_valid", out_valid, 1'b0);
    check("timeout_busy", busy, 1'b0);
    check("timeout_done", done, 1'b0);
    hold_next = 1'b0;
    tick();
    check("timeout_ready", req_ready, 1'b1);
    $display("cmd timeout err after %0d cycles", cnt);
`else
    cnt = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (out_valid && !err && !done) cnt++;
    end
    check("hold_valid", cnt, 120);
    $display("cmd hold next low, valid for %0d cycles", cnt);
    hold_next = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
`endif

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 9) op = 8'($urandom);
      else op = known_ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) == 1) op[3] = 1'b1;
      if ($urandom_range(0, 3) == 0) notready_left = $urandom_range(1, 8);
      run_cmd(op, {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
